// File: rtl/dl_capture_pkg.sv
// Shared types and constants for the delay-line capture controller.
package dl_capture_pkg;

    typedef enum logic [3:0] {
        OP_LOAD   = 4'd0,
        OP_UNLOAD = 4'd1,
        OP_SAMPLE = 4'd2,
        OP_EDGE   = 4'd3,
        OP_ACCUM  = 4'd4,
        OP_STATUS = 4'd5
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CALC,
        ST_ACCUM,
        ST_PUSH
    } state_e;

    localparam int STATUS_TIMEOUT = 7;
    localparam int STATUS_DROP    = 6;
    localparam int STATUS_ILLEGAL = 5;
    localparam int STATUS_FULL    = 4;

    localparam int ACCUM_MAX_K = 7;

endpackage

// File: rtl/dl_tx_fifo.sv
// First-word-fall-through byte FIFO for the TX stream; DEPTH must be a power of 2.
module dl_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot being written when full.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/dl_capture_ctrl.sv
// Byte-command controller for a tapped delay line with a buffered TX stream.
// Define DL_BUBBLE_FILTER_EN to pass captured samples through a 3-tap majority filter.
//   state    | meaning
//   IDLE     | accept a command byte
//   CAPTURE  | waiting for i_dl_valid inside the capture window
//   CALC     | register edge position of the stored sample
//   ACCUM    | add edge position, decide on next sample or result
//   PUSH     | enqueue result byte(s), stalls while the FIFO is full
module dl_capture_ctrl
    import dl_capture_pkg::*;
#(
    parameter int DL_W       = 32,
    parameter int TX_DEPTH   = 4,
    parameter int CAP_WINDOW = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [7:0]      i_data,
    output logic            o_valid,
    input  logic            i_accept,
    output logic [7:0]      o_data,
    input  logic            i_dl_valid,
    input  logic [DL_W-1:0] i_dl,
    output logic            o_busy
);
    localparam int NBYTES      = DL_W / 8;
    localparam int BI_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WIN_W       = (CAP_WINDOW > 2) ? $clog2(CAP_WINDOW) : 1;
    localparam int WIN_FIRST   = (CAP_WINDOW >= 2) ? CAP_WINDOW - 2 : 0;
    localparam int WIN_RESTART = (CAP_WINDOW >= 1) ? CAP_WINDOW - 1 : 0;
    localparam bit WIN_ONE     = (CAP_WINDOW <= 1);

    state_e            r_state, w_state_nx, w_win_nx;
    opcode_e           r_op, w_op, w_cur_op;
    logic [2:0]        r_k;
    logic [DL_W-1:0]   r_data, w_sample;
    logic [7:0]        r_edge, w_edge_pos, w_push_data, w_status;
    logic [14:0]       r_sum;
    logic [7:0]        r_cnt;
    logic [WIN_W-1:0]  r_win;
    logic [BI_W-1:0]   r_bidx;
    logic              r_abort, r_st_timeout, r_st_drop, r_st_illegal;
    logic              w_cmd, w_k_bad, w_illegal, w_capt_op, w_in_window;
    logic              w_cap, w_timeout, w_push, w_last, w_full, w_empty;
    logic [8:0]        w_cnt_nx, w_n;

    assign w_op        = opcode_e'(i_data[3:0]);
    assign w_cmd       = (r_state == ST_IDLE) && i_valid;
    assign w_k_bad     = (i_data[7:4] > 4'(ACCUM_MAX_K));
    assign w_illegal   = (i_data[3:0] > 4'(OP_STATUS)) || (w_op == OP_ACCUM && w_k_bad);
    assign w_capt_op   = w_cmd && (w_op == OP_SAMPLE || w_op == OP_EDGE ||
                                   (w_op == OP_ACCUM && !w_k_bad));
    assign w_cur_op    = (r_state == ST_IDLE) ? w_op : r_op;
    assign w_in_window = w_capt_op || (r_state == ST_CAPTURE);
    assign w_cap       = w_in_window && i_dl_valid;
    assign w_timeout   = w_in_window && !i_dl_valid &&
                         ((r_state == ST_IDLE) ? WIN_ONE : (r_win == '0));
    assign w_cnt_nx    = {1'b0, r_cnt} + 9'd1;
    assign w_n         = 9'd1 << r_k;
    assign w_last      = w_push && (r_op != OP_UNLOAD || r_bidx == '0);

`ifdef DL_BUBBLE_FILTER_EN
    always_comb begin
        w_sample = i_dl;
        for (int i = 1; i < DL_W - 1; i++)
            w_sample[i] = (i_dl[i-1] & i_dl[i]) | (i_dl[i] & i_dl[i+1]) | (i_dl[i-1] & i_dl[i+1]);
    end
`else
    assign w_sample = i_dl;
`endif

    // Ascending scan: the last hit is the highest 1->0 transition.
    always_comb begin
        w_edge_pos = 8'd0;
        for (int j = 1; j < DL_W; j++)
            if (r_data[j-1] && !r_data[j]) w_edge_pos = 8'(j + 1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_win_nx   = ST_CAPTURE;
        if (w_cap)          w_win_nx = (w_cur_op == OP_SAMPLE) ? ST_IDLE : ST_CALC;
        else if (w_timeout) w_win_nx = (w_cur_op == OP_SAMPLE) ? ST_IDLE : ST_PUSH;
        case (r_state)
            ST_IDLE: begin
                if (w_in_window)
                    w_state_nx = w_win_nx;
                else if (i_valid && (w_op == OP_UNLOAD || w_op == OP_STATUS))
                    w_state_nx = ST_PUSH;
            end
            ST_CAPTURE: w_state_nx = w_win_nx;
            ST_CALC:    w_state_nx = (r_op == OP_ACCUM) ? ST_ACCUM : ST_PUSH;
            ST_ACCUM:   w_state_nx = (w_cnt_nx == w_n) ? ST_PUSH : ST_CAPTURE;
            ST_PUSH:    if (w_last) w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != ST_IDLE);
        w_push   = (r_state == ST_PUSH) && !w_full;
        w_status = 8'h00;
        w_status[STATUS_TIMEOUT] = r_st_timeout;
        w_status[STATUS_DROP]    = r_st_drop;
        w_status[STATUS_ILLEGAL] = r_st_illegal;
        w_status[STATUS_FULL]    = w_full;
        w_push_data = 8'h00;
        if (r_abort) w_push_data = 8'hFF;
        else begin
            case (r_op)
                OP_UNLOAD: w_push_data = 8'(r_data >> {r_bidx, 3'b000});
                OP_EDGE:   w_push_data = r_edge;
                OP_ACCUM:  w_push_data = 8'(r_sum >> r_k);
                OP_STATUS: w_push_data = w_status;
                default:   w_push_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op         <= OP_LOAD;
            r_k          <= '0;
            r_data       <= '0;
            r_edge       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_win        <= '0;
            r_bidx       <= '0;
            r_abort      <= 1'b0;
            r_st_timeout <= 1'b0;
            r_st_drop    <= 1'b0;
            r_st_illegal <= 1'b0;
        end else begin
            if (w_cmd) begin
                r_op    <= w_op;
                r_k     <= i_data[6:4];
                r_abort <= 1'b0;
                r_sum   <= '0;
                r_cnt   <= '0;
                r_win   <= WIN_W'(WIN_FIRST);
                r_bidx  <= BI_W'(NBYTES - 1);
                if (w_op == OP_LOAD) r_data <= {r_data[DL_W-5:0], i_data[7:4]};
            end
            if (r_state == ST_CAPTURE) r_win <= r_win - 1'b1;
            if (r_state == ST_ACCUM) begin
                r_sum <= r_sum + 15'(r_edge);
                r_cnt <= r_cnt + 1'b1;
                r_win <= WIN_W'(WIN_RESTART);
            end
            if (w_cap) r_data <= w_sample;
            if (w_timeout && w_cur_op != OP_SAMPLE) r_abort <= 1'b1;
            if (r_state == ST_CALC) r_edge <= w_edge_pos;
            if (w_push && r_op == OP_UNLOAD) r_bidx <= r_bidx - 1'b1;
            // Clear on the status enqueue first so same-cycle events are not lost.
            if (w_push && r_op == OP_STATUS) begin
                r_st_timeout <= 1'b0;
                r_st_drop    <= 1'b0;
                r_st_illegal <= 1'b0;
            end
            if (w_timeout)                        r_st_timeout <= 1'b1;
            if (i_valid && r_state != ST_IDLE)    r_st_drop    <= 1'b1;
            if (w_cmd && w_illegal)               r_st_illegal <= 1'b1;
        end
    end

    dl_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .o_full  (w_full),
        .i_pop   (i_accept),
        .o_empty (w_empty),
        .o_data  (o_data)
    );

    assign o_valid = !w_empty;

endmodule
